// File: rtl/fifo_buf_param.sv
// rtl/fifo_buf_param.sv - parametrised synchronous FIFO with level, almost flags and flush
//
// Purpose: single-clock FIFO between the UART register interface and the
// tx/rx shift engines. Depth may be any integer >= 2; pointers wrap
// explicitly at D-1. Read data is registered (1-cycle latency) with a
// rd_valid strobe. All status flags decode from the registered level only.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN (sticky overflow/underflow flags).
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   flush         synchronous clear of pointers, level and rd_valid
//   wr_en/w_data  write request and data
//   rd_en         read request
//   r_data        registered read data (held across flush)
//   rd_valid      one-cycle strobe: r_data holds newly read data
//   full/empty/not_empty/almost_full/almost_empty  status from level
//   level         occupancy 0..D
//   err_clr       (FIFO_ERR_FLAGS_EN) clear sticky error flags
//   overflow      (FIFO_ERR_FLAGS_EN) sticky write-while-full flag
//   underflow     (FIFO_ERR_FLAGS_EN) sticky read-while-empty flag
module fifo_buf_param #(
  parameter int W         = 8,
  parameter int D         = 16,
  parameter int AF_THRESH = D - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [W-1:0]           w_data,
  input  logic                   rd_en,
  output logic [W-1:0]           r_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   not_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow,
`endif
  output logic [$clog2(D+1)-1:0] level
);

  localparam int PW = $clog2(D);
  localparam int LW = $clog2(D + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(D);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // full/empty come from registered level, so a simultaneous read cannot
  // make room for a write in the same cycle (and vice versa).
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  assign full         = (level == LVL_FULL);
  assign empty        = (level == '0);
  assign not_empty    = ~empty;
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      r_data   <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        r_data <= mem[rd_ptr];
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = wr_en & full & ~flush;
  assign unf_set = rd_en & empty & ~flush;

  // A new error event in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buf_param.sv
// tb/tb_fifo_buf_param.sv - scoreboard testbench for fifo_buf_param (W=8, D=6, AF=4, AE=1)
module tb_fifo_buf_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       wr_en;
  logic [7:0] w_data;
  logic       rd_en;
  logic [7:0] r_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       not_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] level;
`ifdef FIFO_ERR_FLAGS_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
  bit         exp_ovf;
  bit         exp_unf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         exp_valid;
  logic [7:0] exp_rdata;
  logic [7:0] exp_d;

  fifo_buf_param #(.W(8), .D(6), .AF_THRESH(4), .AE_THRESH(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr_en        (wr_en),
    .w_data       (w_data),
    .rd_en        (rd_en),
    .r_data       (r_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .not_empty    (not_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .level        (level)
  );

  always #5 clk = ~clk;

  // Drives one clock of stimulus and advances the reference model; expected
  // read data is pushed onto sb when the model accepts a read.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    bit wacc;
    bit racc;
    wr_en  = we;
    w_data = wd;
    rd_en  = re;
    flush  = fl;
    wacc = we && (mq.size() < 6) && !fl;
    racc = re && (mq.size() > 0) && !fl;
`ifdef FIFO_ERR_FLAGS_EN
    if (fl) begin
      exp_ovf = 0;
      exp_unf = 0;
    end else begin
      if (we && mq.size() == 6) exp_ovf = 1;
      else if (err_clr) exp_ovf = 0;
      if (re && mq.size() == 0) exp_unf = 1;
      else if (err_clr) exp_unf = 0;
    end
`endif
    if (fl) begin
      mq.delete();
      sb.delete();
    end
    if (racc) begin
      exp_rdata = mq.pop_front();
      sb.push_back(exp_rdata);
    end
    if (wacc) mq.push_back(wd);
    exp_valid = racc;
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
    flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; wr_en = 0; rd_en = 0; w_data = 0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 0; exp_ovf = 0; exp_unf = 0;
`endif
    mq.delete(); sb.delete(); exp_valid = 0; exp_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({empty, not_empty, full} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {empty, not_empty, full}); end
    checks++; if ({almost_empty, almost_full} !== 2'b10) begin failures++; $display("FAIL reset_almost got=%b exp=10", {almost_empty, almost_full}); end
    checks++; if ({rd_valid, r_data} !== 9'h000) begin failures++; $display("FAIL reset_rdata got=%b/%h exp=0/00", rd_valid, r_data); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
`endif
    reset = 0;
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h11 + 8'(i), 0, 0);
      checks++; if (level !== 3'(mq.size())) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level, mq.size()); end
      checks++;
      if ({almost_empty, almost_full, full} !== {mq.size() <= 1, mq.size() >= 4, mq.size() == 6}) begin
        failures++; $display("FAIL fill_flags lvl=%0d got=%b exp=%b", mq.size(), {almost_empty, almost_full, full},
                             {mq.size() <= 1, mq.size() >= 4, mq.size() == 6});
      end
    end
    step(1, 8'h77, 0, 0);
    checks++; if (level !== 3'd6 || full !== 1'b1) begin failures++; $display("FAIL overfill got=%0d/%b exp=6/1", level, full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%b exp=1", rd_valid); end
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++; if (r_data !== exp_d) begin failures++; $display("FAIL drain_data got=%h exp=%h", r_data, exp_d); end
      end
    end
    checks++; if (empty !== 1'b1 || level !== 3'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, level); end
    step(0, 8'h00, 1, 0);
    checks++; if (rd_valid !== 1'b0 || r_data !== 8'h16) begin failures++; $display("FAIL underread got=%b/%h exp=0/16", rd_valid, r_data); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom_range(0, 255)), 1, 0);
      checks++; if (level !== 3'd3 || rd_valid !== 1'b1) begin failures++; $display("FAIL wrap_level i=%0d got=%0d/%b exp=3/1", i, level, rd_valid); end
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++; if (r_data !== exp_d) begin failures++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, r_data, exp_d); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++; if (r_data !== exp_d) begin failures++; $display("FAIL wrap_tail got=%h exp=%h", r_data, exp_d); end
      end
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 6; i++) step(1, 8'h30 + 8'(i), 0, 0);
    step(1, 8'h99, 1, 0);
    checks++; if (level !== 3'd5 || rd_valid !== 1'b1 || r_data !== 8'h30) begin
      failures++; $display("FAIL full_simul got=%0d/%b/%h exp=5/1/30", level, rd_valid, r_data);
    end
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0);
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++; if (r_data !== exp_d) begin failures++; $display("FAIL full_simul_data got=%h exp=%h", r_data, exp_d); end
      end
    end
    step(1, 8'h5A, 1, 0);
    checks++; if (level !== 3'd1 || rd_valid !== 1'b0) begin failures++; $display("FAIL empty_simul got=%0d/%b exp=1/0", level, rd_valid); end
    step(0, 8'h00, 1, 0);
    checks++; if (rd_valid !== 1'b1 || r_data !== 8'h5A) begin failures++; $display("FAIL empty_simul_data got=%b/%h exp=1/5a", rd_valid, r_data); end
    sb.delete();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0, 0);
    step(0, 8'h00, 1, 0);
    sb.delete();
    step(1, 8'hC4, 0, 0);
    step(1, 8'hEE, 1, 1);
    checks++; if (level !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL flush_state got=%0d/%b/%b exp=0/1/0", level, empty, rd_valid);
    end
    checks++; if (r_data !== exp_rdata) begin failures++; $display("FAIL flush_rdata got=%h exp=%h", r_data, exp_rdata); end
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    wr_en = 1; w_data = 8'h03;
    #2 reset = 1;
    #1;
    checks++; if (level !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL async_reset got=%0d/%b exp=0/1", level, empty); end
    wr_en = 0;
    #1 reset = 0;
    mq.delete(); sb.delete(); exp_rdata = 8'h00;
    step(0, 8'h00, 0, 0);
    checks++; if (level !== 3'd0 || r_data !== 8'h00) begin failures++; $display("FAIL post_reset got=%0d/%h exp=0/00", level, r_data); end
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    for (int i = 0; i < 6; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_set got=%b exp=%b", overflow, exp_ovf); end
    step(0, 8'h00, 0, 0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    err_clr = 1;
    step(0, 8'h00, 0, 0);
    err_clr = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
    sb.delete();
    step(0, 8'h00, 1, 0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", underflow); end
    err_clr = 1;
    step(0, 8'h00, 1, 0);
    err_clr = 0;
    checks++; if (underflow !== 1'b1 || underflow !== exp_unf) begin failures++; $display("FAIL unf_set_wins got=%b exp=1", underflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_boundary();
    test_flush();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_buf_param.md
Name: fifo_buf_param

Overview:
- Parametrised synchronous FIFO for the UART TX and RX paths.
- Successor to the fixed 8x8 buffer. Adds:
  - arbitrary (non-power-of-2) depth
  - occupancy level output
  - programmable almost-full and almost-empty flags
  - synchronous flush
  - read-data valid strobe
- Sits between the UART register interface and the tx/rx shift engines. Single clock domain.

Parameters:
- W, 8, data width in bits (>=1).
- D, 16, depth in entries (>=2, any integer).
- AF_THRESH, D-2, almost_full asserts when level >= AF_THRESH (1..D).
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH (0..D-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset. All state is cleared immediately on assertion.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  write request.
- w_data  in  W  write data.
- rd_en  in  1  read request.
- r_data  out  W  registered read data.
- rd_valid  out  1  high for one cycle when r_data holds newly read data.
- full  out  1  level == D.
- empty  out  1  level == 0.
- not_empty  out  1  ~empty.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(D+1)  current occupancy, 0..D.

Behaviour:
- Reset values:
  - wr_ptr, rd_ptr, level, r_data, rd_valid = 0.
  - empty = 1, not_empty = 0, full = 0.
  - almost_empty = 1. almost_full = 1 only if AF_THRESH == 0 (illegal; not used).
  - Memory contents are not reset; they are unobservable while empty.
- Write acceptance:
  - wr_acc = wr_en & ~full & ~flush.
  - On wr_acc: mem[wr_ptr] <= w_data, and wr_ptr advances.
- Read acceptance:
  - rd_acc = rd_en & ~empty & ~flush.
  - On rd_acc: r_data <= mem[rd_ptr], and rd_ptr advances.
  - rd_valid is registered and equals rd_acc of the previous cycle. Read latency is 1 cycle.
- Pointers:
  - $clog2(D) bits wide. Wrap explicitly from D-1 to 0; no reliance on power-of-2 overflow.
- Level:
  - wr_acc & ~rd_acc: +1.
  - rd_acc & ~wr_acc: -1.
  - Both or neither: unchanged.
  - All flags decode from level, registered state only (no combinational path from wr_en/rd_en to the flags).
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected (full is evaluated before the read). Level drops to D-1.
  - When empty: the write is accepted, the read is rejected. rd_valid stays 0. Level becomes 1.
  - Otherwise both are accepted and level is unchanged.
- Overflow/underflow attempts:
  - Write while full and read while empty are ignored silently.
  - Pointers, level, r_data and memory are unchanged.
- Flush (synchronous):
  - Next edge: wr_ptr, rd_ptr, level and rd_valid become 0.
  - r_data holds its last value.
  - Flush overrides wr_en and rd_en in the same cycle.
- Reset asserted mid-operation:
  - Immediate return to reset values, regardless of the clock.
  - Any read or write in flight is lost.
- No storage or pipeline stages beyond mem, pointers, level, r_data and rd_valid.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, adds these ports:
  - err_clr in 1
  - overflow out 1
  - underflow out 1
- overflow sets on any cycle with wr_en & full & ~flush.
- underflow sets on any cycle with rd_en & empty & ~flush.
- Both flags are sticky until err_clr, or until flush or reset, which clear them.
- If a set condition and err_clr occur in the same cycle, set wins.
- Both reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Config W=8, D=6, AF_THRESH=4, AE_THRESH=1, for all tests unless stated.
- Reset, then write 0x11..0x16 over 6 cycles:
  - level counts 1..6.
  - almost_empty drops when level reaches 2.
  - almost_full rises at level 4.
  - full rises at level 6.
  - A 7th write of 0x77 is ignored (level stays 6).
- Read 6 times from full:
  - r_data = 0x11..0x16, each with rd_valid pulsed 1 cycle after its rd_en.
  - Pointers wrap 5->0. empty = 1 after the 6th read.
  - A 7th read leaves r_data = 0x16 with rd_valid = 0.
- Wrap stress: 20 cycles of continuous simultaneous write and read at level 3:
  - Level stays 3.
  - Output order matches input order across multiple wraps.
- Boundary simultaneity:
  - At full, wr_en & rd_en: level 5, and the written data is not stored.
  - At empty, wr_en & rd_en: level 1, rd_valid = 0, and the next read returns the written data.
- Flush at level 4 with wr_en & rd_en high:
  - Next cycle: level 0, empty = 1, rd_valid = 0, r_data unchanged.
  - Async reset pulsed mid-write: level 0 before the next clock edge.
- FIFO_ERR_FLAGS_EN defined:
  - Write at full: overflow = 1 and it stays set.
  - err_clr: overflow returns to 0.
  - Read at empty: underflow = 1.
  - err_clr together with a new underflow: underflow stays 1.
